ram8_arbiter: RTL
=================

# ram8_arbiter

Two-port arbiter and sequencer in front of one 8-word × 16-bit RAM8 memory. After reset, it zero-fills all eight words. It then shares the single RAM port between requesters A and B using round-robin arbitration. Writes commit on the grant edge; read data returns one cycle later through a registered response. It sits between the RAM8 instance and the two client blocks, and is the only driver of the RAM's load, address and in pins.

## Interface
- No parameters. Data width is 16, address width is 3, depth is 8; all are fixed by RAM8.
- clk  in  1  system clock; every register updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  requester A has a transaction pending; held until a_gnt is sampled high
- a_we  in  1  1 = write, 0 = read; stable while a_req is high
- a_addr  in  3  word address
- a_wdata  in  16  write data
- a_gnt  out  1  combinational; A's transaction is accepted on this edge
- a_rvalid  out  1  one-cycle pulse; a_rdata holds A's read result
- a_rdata  out  16  registered read data; holds its value until A's next read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
- busy  out  1  high during zero-fill; no grants are issued while high
- ram_load  out  1  to RAM8 load
- ram_address  out  3  to RAM8 address
- ram_in  out  16  to RAM8 in
- ram_out  in  16  from RAM8 out; combinational read of ram_address

## Operation
- **FSM states:** INIT and RUN.
- **INIT:**
  - 3-bit counter fill_cnt steps 0..7.
  - Outputs: ram_load=1, ram_address=fill_cnt, ram_in=0, busy=1, both gnt=0.
  - When fill_cnt=7 at an edge, the FSM moves to RUN and busy falls.
- **RUN, arbitration each cycle:**
  - Only one requester high: grant it.
  - Both high: grant the requester that was not granted most recently.
  - Neither high: ram_load=0, ram_address=0, ram_in=0.
- **last_gnt register:** updates only on a grant. Reset value is B, so A wins the first contention.
- **Granted write:** ram_load=1, ram_address=x_addr, ram_in=x_wdata. RAM8 commits the data on the same edge. No rvalid is produced.
- **Granted read:** ram_load=0, ram_address=x_addr. ram_out is captured into x_rdata at the edge, and x_rvalid=1 for the following cycle.
- **Read contents:** a read returns the contents before any write on that edge. A single access per cycle means no read/write collision can occur.
- **Back-to-back requests:** a requester may present its next request in the cycle after a grant. Throughput is one transaction per cycle total, shared between A and B.
- **Request rules:**
  - A requester whose req is low is never granted.
  - Address, we and wdata are don't-care while req is low.

## Timing
- **Reset values:** state=INIT, fill_cnt=0, last_gnt=B, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, busy=1, gnt=0.
- **During reset:** ram_load=1 and ram_address=0, so the fill of word 0 is already in progress.
- **INIT length:** exactly 8 rising edges after reset deasserts. The first possible grant is in cycle 8, counting the first post-reset cycle as 0.
- **Grant latency:** a_gnt is combinational from a_req, state and last_gnt in the same cycle. There is no path from a_gnt back into a_req.
- **Read latency:** request accepted at edge N gives x_rvalid high and x_rdata valid during cycle N+1. rvalid is high for exactly one cycle per read.
- **Reset mid-operation:**
  - All state returns to reset values and INIT restarts from word 0.
  - Any in-flight read never produces rvalid.
  - A write granted on the same edge as the reset assertion is not guaranteed to commit.
- **Requests during INIT:** requests stay pending and are not dropped. They are arbitrated from cycle 8.

## Structure
- **Package ram8_arb_pkg:**
  - state encoding (INIT, RUN)
  - requester ID encoding (REQ_A=0, REQ_B=1)
  - widths DATA_W=16, ADDR_W=3, DEPTH=8
- **Sub-module rr_arb2:** a two-requester round-robin arbiter holding last_gnt.
  - Inputs: clk, reset, req[1:0], enable (=RUN).
  - Output: one-hot gnt[1:0].
- **ram8_arbiter:** instantiates rr_arb2 and contains the fill FSM, the RAM port mux and the two read-response registers.

## Test plan
- **Reset and fill:** pulse reset, hold a_req=1. Expect ram_load=1 with addresses 0..7 and ram_in=0 over cycles 0–7, busy=1, no gnt. busy=0 and a_gnt=1 in cycle 8. Then read every word: all return 0x0000.
- **Write then read (A):** write 0xBEEF to addr 5, then read addr 5 in the next cycle. Expect a_rvalid one cycle after the read grant, with a_rdata=0xBEEF and b_rvalid=0.
- **Contention:** a_req and b_req held high for 4 cycles, all reads. Expect grants A,B,A,B. Each rvalid is on the correct side, and rdata matches previously written values 0x1111 (addr 1) and 0x2222 (addr 2).
- **Single requester streaming:** B alone issues 8 back-to-back writes of 0x0100+i to addr i. Expect b_gnt high for all 8 cycles. A later readback of all 8 words matches.
- **Reset mid-read:** assert reset in the cycle after a read grant. Expect a_rvalid to stay 0, busy=1, and the fill to restart at addr 0.

Source files
------------

// File: rtl/ram8_arb_pkg.sv
// Shared widths and encodings for the RAM8 arbiter and its round-robin core.
package ram8_arb_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;
endpackage

// File: rtl/ram8_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on contention the requester not granted
// most recently wins. Grants are combinational, history updates on a grant.
module rr_arb2
    import ram8_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);
    req_id_t r_last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (r_last_gnt == REQ_B) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset favours B as "last" so A wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= REQ_B;
        end else if (gnt[1]) begin
            r_last_gnt <= REQ_B;
        end else if (gnt[0]) begin
            r_last_gnt <= REQ_A;
        end
    end
endmodule

// File: rtl/ram8_arbiter.sv
// Zero-fills RAM8 after reset, then shares its single port between A and B
// with round-robin arbitration and registered read responses.
module ram8_arbiter
    import ram8_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);
    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [1:0]        w_gnt;
    logic [1:0]        w_we;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata [2];

    assign w_we = {b_we, a_we};

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({b_req, a_req}),
        .enable (r_state == ST_RUN),
        .gnt    (w_gnt)
    );

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && r_fill_cnt == ADDR_W'(DEPTH - 1)) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_fill_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
            end
        end
    end

    // RAM port mux: fill during INIT, otherwise the granted requester or idle zeros.
    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        if (r_state == ST_INIT) begin
            ram_load    = 1'b1;
            ram_address = r_fill_cnt;
        end else if (w_gnt[0]) begin
            ram_load    = a_we;
            ram_address = a_addr;
            ram_in      = a_we ? a_wdata : '0;
        end else if (w_gnt[1]) begin
            ram_load    = b_we;
            ram_address = b_addr;
            ram_in      = b_we ? b_wdata : '0;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rvalid[gi] <= 1'b0;
                    r_rdata[gi]  <= '0;
                end else begin
                    r_rvalid[gi] <= w_gnt[gi] & ~w_we[gi];
                    if (w_gnt[gi] && !w_we[gi]) begin
                        r_rdata[gi] <= ram_out;
                    end
                end
            end
        end
    endgenerate

    assign busy     = (r_state == ST_INIT);
    assign a_gnt    = w_gnt[0];
    assign b_gnt    = w_gnt[1];
    assign a_rvalid = r_rvalid[0];
    assign b_rvalid = r_rvalid[1];
    assign a_rdata  = r_rdata[0];
    assign b_rdata  = r_rdata[1];
endmodule
